// File: rtl/counter4bit_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : counter4bit_stepper
// Description : KEY0 front end for the 4-bit sequence counter. Synchronises
//               and debounces the active-low key, holds the present-state
//               register fed to counter4bitlogic, loads its D output once per
//               accepted press and recovers illegal codes to 0000.
// Revision    : 1.0 - initial release
// ============================================================================
module counter4bit_stepper #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] D,
    input  logic       load_en,
    input  logic [3:0] load_val,
    output logic [3:0] present,
    output logic       step,
    output logic       wrap,
    output logic       illegal_fix,
    output logic       pressed
);

    // One extra bit keeps the counter from ever wrapping at the terminal count.
    localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     c_WRAP_CODE = 4'b1001;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    logic             r_sync1;
    logic             r_key_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_adv;
    logic             w_adv_nxt;
    logic             w_legal;
    logic [3:0]       r_present;
    logic             r_step;
    logic             r_wrap;
    logic             r_fix;

    // Two-flop synchroniser; idles at 1 so reset looks like a released key.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_key_s <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_key_s <= r_sync1;
        end
    end

    // Debounce state register, stability counter and registered advance pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_adv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_adv   <= w_adv_nxt;
        end
    end

    // Debounce next-state: a level must hold DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_adv_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_key_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (r_key_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_HELD;
                    w_adv_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            S_HELD: begin
                if (r_key_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (!r_key_s) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Debounced key level: held from acceptance until a release is confirmed.
    always_comb begin
        pressed = 1'b0;
        case (r_state)
            S_HELD, S_RELEASE_WAIT: pressed = 1'b1;
            default:                pressed = 1'b0;
        endcase
    end

    // Legal-code decode for the 12-state sequence; D is meaningless otherwise.
    always_comb begin
        w_legal = 1'b0;
        case (r_present)
            4'b0000, 4'b1110, 4'b1101, 4'b1100,
            4'b1000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1010, 4'b0101, 4'b1001: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    // Present-state register: load beats advance; illegal codes recover to 0000.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_present <= 4'b0000;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
            r_fix     <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            r_fix  <= 1'b0;
            if (load_en) begin
                r_present <= load_val;
            end else if (r_adv && w_legal) begin
                r_present <= D;
                r_step    <= 1'b1;
                r_wrap    <= (r_present == c_WRAP_CODE);
            end else if (r_adv) begin
                r_present <= 4'b0000;
                r_step    <= 1'b1;
                r_fix     <= 1'b1;
            end
        end
    end

    assign present     = r_present;
    assign step        = r_step;
    assign wrap        = r_wrap;
    assign illegal_fix = r_fix;

endmodule
`default_nettype wire

// File: tb/tb_counter4bit_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_counter4bit_stepper
// Description : Directed self-checking bench for counter4bit_stepper with
//               DEBOUNCE_CYCLES = 4 and a behavioural counter4bitlogic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter4bit_stepper;

    logic       clock;
    logic       reset;
    logic       key_n;
    logic [3:0] D;
    logic       load_en;
    logic [3:0] load_val;
    logic [3:0] present;
    logic       step;
    logic       wrap;
    logic       illegal_fix;
    logic       pressed;

    int n_cmp;
    int n_err;
    int step_cnt;
    int wrap_cnt;
    int fix_cnt;
    int pressed_cnt;

    counter4bit_stepper #(.DEBOUNCE_CYCLES(4)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_n),
        .D           (D),
        .load_en     (load_en),
        .load_val    (load_val),
        .present     (present),
        .step        (step),
        .wrap        (wrap),
        .illegal_fix (illegal_fix),
        .pressed     (pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural next-state block; illegal codes return a poison value.
    function automatic logic [3:0] nxt(input logic [3:0] p);
        case (p)
            4'b0000: nxt = 4'b1110;
            4'b1110: nxt = 4'b1101;
            4'b1101: nxt = 4'b1100;
            4'b1100: nxt = 4'b1000;
            4'b1000: nxt = 4'b0001;
            4'b0001: nxt = 4'b0011;
            4'b0011: nxt = 4'b0111;
            4'b0111: nxt = 4'b1111;
            4'b1111: nxt = 4'b1010;
            4'b1010: nxt = 4'b0101;
            4'b0101: nxt = 4'b1001;
            4'b1001: nxt = 4'b0000;
            default: nxt = 4'b1011;
        endcase
    endfunction

    assign D = nxt(present);

    // Pulse and level tallies, sampled away from the active edge.
    initial begin
        step_cnt = 0; wrap_cnt = 0; fix_cnt = 0; pressed_cnt = 0;
        forever begin
            @(negedge clock);
            if (step)        step_cnt++;
            if (wrap)        wrap_cnt++;
            if (illegal_fix) fix_cnt++;
            if (pressed)     pressed_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int low, input int high);
        key_n = 1'b0;
        cyc(low);
        key_n = 1'b1;
        cyc(high);
    endtask

    logic [3:0] seq [12];
    int s0, w0, f0, p0;

    initial begin
        n_cmp = 0; n_err = 0;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2]  = 4'b1100; seq[3]  = 4'b1000;
        seq[4] = 4'b0001; seq[5] = 4'b0011; seq[6]  = 4'b0111; seq[7]  = 4'b1111;
        seq[8] = 4'b1010; seq[9] = 4'b0101; seq[10] = 4'b1001; seq[11] = 4'b0000;

        reset = 1'b1; key_n = 1'b1; load_en = 1'b0; load_val = 4'b0000;
        cyc(3);
        check("rst_present", 32'(present), 32'h0);
        check("rst_pulses", {29'd0, step, wrap, illegal_fix}, 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        reset = 1'b0;
        cyc(2);

        // Twelve clean presses walk the full sequence; wrap only on the last.
        s0 = step_cnt; w0 = wrap_cnt;
        for (int i = 0; i < 12; i++) begin
            press(10, 10);
            check($sformatf("walk_%0d", i), 32'(present), 32'(seq[i]));
            if (i == 10) check("walk_nowrap_yet", 32'(wrap_cnt - w0), 32'd0);
        end
        check("walk_steps", 32'(step_cnt - s0), 32'd12);
        check("walk_wraps", 32'(wrap_cnt - w0), 32'd1);

        // Bounce shorter than the debounce window is rejected.
        s0 = step_cnt; p0 = pressed_cnt;
        key_n = 1'b0; cyc(3);
        key_n = 1'b1; cyc(1);
        key_n = 1'b0; cyc(3);
        key_n = 1'b1; cyc(10);
        check("bounce_steps", 32'(step_cnt - s0), 32'd0);
        check("bounce_present", 32'(present), 32'h0);
        check("bounce_pressed", 32'(pressed_cnt - p0), 32'd0);

        // Long hold: exactly one step at edge k+6, pressed drops 4 cycles after key_s rises.
        s0 = step_cnt;
        key_n = 1'b0;
        cyc(6);
        check("hold_before", 32'(present), 32'h0);
        check("hold_step_before", 32'(step), 32'h0);
        cyc(1);
        check("hold_present", 32'(present), 32'he);
        check("hold_step", 32'(step), 32'h1);
        cyc(1);
        check("hold_step_one", 32'(step), 32'h0);
        cyc(42);
        key_n = 1'b1;
        cyc(5);
        check("rel_pressed_hi", 32'(pressed), 32'h1);
        cyc(1);
        check("rel_pressed_lo", 32'(pressed), 32'h0);
        cyc(5);
        check("hold_steps", 32'(step_cnt - s0), 32'd1);

        // Illegal code recovers to 0000 on the next press.
        load_en = 1'b1; load_val = 4'b0100;
        cyc(1);
        load_en = 1'b0;
        check("load_illegal", 32'(present), 32'h4);
        check("load_no_step", 32'(step), 32'h0);
        f0 = fix_cnt; w0 = wrap_cnt;
        key_n = 1'b0;
        cyc(7);
        check("fix_present", 32'(present), 32'h0);
        check("fix_pulses", {29'd0, step, wrap, illegal_fix}, 32'h5);
        cyc(1);
        check("fix_one_cycle", 32'(illegal_fix), 32'h0);
        cyc(2);
        key_n = 1'b1; cyc(10);
        check("fix_count", 32'(fix_cnt - f0), 32'd1);
        check("fix_wraps", 32'(wrap_cnt - w0), 32'd0);
        press(10, 10);
        check("after_fix", 32'(present), 32'he);

        // Load coincident with adv wins and drops the step.
        s0 = step_cnt;
        key_n = 1'b0;
        cyc(6);
        load_en = 1'b1; load_val = 4'b1111;
        cyc(1);
        load_en = 1'b0;
        check("ldadv_present", 32'(present), 32'hf);
        check("ldadv_step", 32'(step), 32'h0);
        cyc(3);
        key_n = 1'b1; cyc(10);
        check("ldadv_steps", 32'(step_cnt - s0), 32'd0);
        press(10, 10);
        check("ldadv_next", 32'(present), 32'ha);

        // Reset during PRESS_WAIT; the still-low key is a fresh press afterwards.
        load_en = 1'b1; load_val = 4'b1100;
        cyc(1);
        load_en = 1'b0;
        check("pre_rst_present", 32'(present), 32'hc);
        key_n = 1'b0;
        cyc(3);
        check("pre_rst_pressed", 32'(pressed), 32'h0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_present", 32'(present), 32'h0);
        check("mid_rst_outs", {28'd0, step, wrap, illegal_fix, pressed}, 32'h0);
        cyc(2);
        reset = 1'b0;
        s0 = step_cnt;
        cyc(6);
        check("post_rst_before", 32'(present), 32'h0);
        cyc(1);
        check("post_rst_present", 32'(present), 32'he);
        check("post_rst_step", 32'(step), 32'h1);
        cyc(3);
        key_n = 1'b1; cyc(10);
        check("post_rst_steps", 32'(step_cnt - s0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter4bit_stepper.md
# counter4bit_stepper

Sequential front end for the 4-bit KEY0-driven sequence counter. It synchronises and debounces the raw active-low KEY0 input, holds the 4-bit present-state register, and feeds `present` to the combinational next-state block (`counter4bitlogic`). On each accepted press it loads the next-state block's `D` output. Codes that fall outside the 12-state sequence are recovered to 0000.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a press or a release. Legal range ≥ 2. Simulation uses 4.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- key_n  in  1  raw KEY0 input, active-low (0 = pressed), asynchronous and bouncy
- D  in  4  next-state code from `counter4bitlogic`
- load_en  in  1  synchronous load strobe
- load_val  in  4  value loaded into `present` when `load_en` = 1; any code is allowed, including illegal ones
- present  out  4  registered present state; drives `counter4bitlogic`
- step  out  1  one-cycle pulse in the first cycle `present` shows a stepped value
- wrap  out  1  one-cycle pulse when a step goes 1001 → 0000
- illegal_fix  out  1  one-cycle pulse when a press recovers an illegal state to 0000
- pressed  out  1  debounced key level (1 = held)

## Operation

- Legal sequence: 0000 → 1110 → 1101 → 1100 → 1000 → 0001 → 0011 → 0111 → 1111 → 1010 → 0101 → 1001 → 0000.
- Illegal codes: all other codes (0010, 0100, 0110, 1011). `D` is undefined (x) for these codes and must never be loaded when `present` is illegal.
- Synchroniser:
  - Two flops on `key_n`.
  - Both reset to 1 (released).
  - The second-flop output is `key_s`.
- Debounce FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: `key_s` = 0 → PRESS_WAIT, counter = 1.
  - PRESS_WAIT: `key_s` = 1 → IDLE, counter cleared. Counter = DEBOUNCE_CYCLES−1 with `key_s` = 0 → HELD and raise an internal one-cycle `adv`. Otherwise increment the counter.
  - HELD: `key_s` = 1 → RELEASE_WAIT, counter = 1.
  - RELEASE_WAIT: `key_s` = 0 → HELD, counter cleared. Counter = DEBOUNCE_CYCLES−1 with `key_s` = 1 → IDLE. Otherwise increment the counter.
  - `pressed` = 1 in HELD and RELEASE_WAIT.
- State register update priority, on the edge after `adv`:
  1. `load_en` = 1: `present` ← `load_val`. No step, wrap or illegal_fix pulse. A coincident `adv` is dropped.
  2. `adv` = 1 and `present` legal: `present` ← `D`, `step` = 1. `wrap` = 1 if the old value was 1001.
  3. `adv` = 1 and `present` illegal: `present` ← 0000, `step` = 1, `illegal_fix` = 1.
  4. Otherwise: hold.
- Holding the key yields exactly one step. A new step requires a debounced release followed by a debounced press.
- Reset values: `present` = 0000; `step`, `wrap`, `illegal_fix`, `pressed` = 0; FSM in IDLE; counter = 0.
- Counter width: ceil(log2(DEBOUNCE_CYCLES)) + 1 bits. The counter never wraps.

## Timing

- Latency: when `key_n` is first sampled low at edge k and stays low, `present` and `step` update at edge k + DEBOUNCE_CYCLES + 2.
- Pulse outputs are registered and high for exactly one cycle.
- `load_en` takes effect at the next edge; `present` shows `load_val` one cycle later.
- Reset mid-operation:
  - Asserting `reset` clears everything asynchronously, including a debounce in progress. No `step` is emitted for the interrupted press.
  - If `key_n` is still low after `reset` deasserts, it is treated as a fresh press. It is accepted DEBOUNCE_CYCLES + 2 edges after the first sampling edge.
- Release-side bounce shorter than DEBOUNCE_CYCLES is ignored and `pressed` stays 1.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

- Reset, then 12 clean presses (each 10 cycles low, 10 high) → `present` walks 1110, 1101, …, 1001, 0000. `step` pulses 12 times. `wrap` pulses once, on the 12th press.
- Press bounce: `key_n` low 3 cycles, high 1, low 3, high → no `step`, `present` stays 0000, `pressed` stays 0.
- Hold `key_n` low 50 cycles → exactly one `step`; `present` 0000 → 1110 at edge k+6. `pressed` = 1 until 4 cycles after release reaches `key_s`.
- `load_en` with `load_val` = 0100, then one press → `present` = 0000 and `step` = `illegal_fix` = 1 for one cycle. The next press gives 1110.
- `load_en` = 1 with `load_val` = 1111 in the same cycle as `adv` → `present` = 1111, no `step`. The following press gives 1010.
- Assert `reset` while in PRESS_WAIT with `present` = 1100, keeping `key_n` low → outputs clear immediately. After release of `reset`, the press is accepted and `present` = 1110.
